// File: rtl/barker_pkg.sv
// Shared definitions for the Barker-13 framer and its correlator: the preamble
// length, the preamble constant and the framer state encoding.
// The GAP state exists only when BARKER_FRAMER_GUARD_EN is defined.
package barker_pkg;

    localparam int BARKER_LEN = 13;

    // Sent left bit first, so index BARKER_LEN-1 leaves the framer first.
    localparam logic [BARKER_LEN-1:0] BARKER13 = 13'b1111100110101;

    // Index of the final preamble chip.
    localparam logic [3:0] PRE_LAST = 4'(BARKER_LEN - 1);

`ifdef BARKER_FRAMER_GUARD_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4
    } framer_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3
    } framer_state_e;
`endif

    // Preamble chip k in transmission order (k = 0 is the leftmost chip).
    function automatic logic preamble_bit(input logic [3:0] k);
        return BARKER13[PRE_LAST - k];
    endfunction

endpackage

// File: rtl/barker_framer.sv
// Barker-13 framer: emits the 13-chip preamble followed by the payload bytes
// MSB-first on a 1-bit AXI-Stream. A frame ends after PAYLOAD_BYTES bytes or
// earlier on s_axis_tlast (flagged by o_short). Each byte costs one LOAD
// bubble, giving 13 + 9*N cycles per N-byte frame at full downstream rate.
// Optional feature macro BARKER_FRAMER_GUARD_EN: after each frame, hold the
// output idle for GUARD_LEN cycles before the next preamble may start.
module barker_framer
    import barker_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 4,
    parameter int GUARD_LEN     = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    output logic       m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    input  logic       m_axis_tready,
    output logic       o_short
);

    if (PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 255) begin : g_bad_payload
        $error("barker_framer: PAYLOAD_BYTES must be 1..255");
    end
    if (GUARD_LEN < 1 || GUARD_LEN > 255) begin : g_bad_guard
        $error("barker_framer: GUARD_LEN must be 1..255");
    end

    localparam logic [7:0] PB = 8'(PAYLOAD_BYTES);

    framer_state_e state_q, state_d;
    logic [3:0]    pre_q, pre_d;     // preamble chip index
    logic [2:0]    bit_q, bit_d;     // payload bit index, 7 down to 0
    logic [7:0]    byte_q, byte_d;   // captured payload byte
    logic          last_q, last_d;   // captured s_axis_tlast
    logic [7:0]    cnt_q, cnt_d;     // bytes captured in this frame
    logic          at_limit;

`ifdef BARKER_FRAMER_GUARD_EN
    localparam logic [7:0] GAP_LAST = 8'(GUARD_LEN - 1);
    logic [7:0] gap_q, gap_d;        // guard cycles elapsed
`endif

    // Counter never exceeds PB, so it cannot wrap inside a frame.
    assign at_limit = (cnt_q >= PB);

    // Next-state, datapath updates and stream outputs.
    always_comb begin
        state_d       = state_q;
        pre_d         = pre_q;
        bit_d         = bit_q;
        byte_d        = byte_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
`ifdef BARKER_FRAMER_GUARD_EN
        gap_d         = gap_q;
`endif
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 1'b0;
        m_axis_tlast  = 1'b0;
        o_short       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The waiting byte stays on the input until LOAD takes it.
                if (s_axis_tvalid) begin
                    state_d = ST_PRE;
                    pre_d   = 4'd0;
                end
            end

            ST_PRE: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = preamble_bit(pre_q);
                if (m_axis_tready) begin
                    if (pre_q == PRE_LAST) begin
                        pre_d   = 4'd0;
                        state_d = ST_LOAD;
                    end else begin
                        pre_d = pre_q + 4'd1;
                    end
                end
            end

            ST_LOAD: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    byte_d  = s_axis_tdata;
                    last_d  = s_axis_tlast;
                    cnt_d   = cnt_q + 8'd1;
                    bit_d   = 3'd7;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = byte_q[bit_q];
                m_axis_tlast  = (bit_q == 3'd0) && (at_limit || last_q);
                if (m_axis_tready) begin
                    if (bit_q != 3'd0) begin
                        bit_d = bit_q - 3'd1;
                    end else if (!at_limit && !last_q) begin
                        state_d = ST_LOAD;
                    end else begin
                        // Frame end; tlast beyond the count is simply ignored.
                        o_short = last_q && !at_limit;
                        cnt_d   = 8'd0;
                        last_d  = 1'b0;
`ifdef BARKER_FRAMER_GUARD_EN
                        gap_d   = 8'd0;
                        state_d = ST_GAP;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end

`ifdef BARKER_FRAMER_GUARD_EN
            ST_GAP: begin
                // The last guard cycle doubles as the IDLE decision so the
                // output is quiet for exactly GUARD_LEN cycles between frames.
                if (gap_q == GAP_LAST) begin
                    gap_d   = 8'd0;
                    pre_d   = 4'd0;
                    state_d = s_axis_tvalid ? ST_PRE : ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pre_q   <= 4'd0;
            bit_q   <= 3'd0;
            byte_q  <= 8'd0;
            last_q  <= 1'b0;
            cnt_q   <= 8'd0;
`ifdef BARKER_FRAMER_GUARD_EN
            gap_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
`ifdef BARKER_FRAMER_GUARD_EN
            gap_q   <= gap_d;
`endif
        end
    end

endmodule

// File: tb/tb_barker_framer.sv
// Bench for barker_framer: two instances (4-byte and 1-byte payloads) driven
// from a per-cycle stimulus task; expected chips are queued when bytes are
// sent and popped as the DUT hands beats downstream.
`timescale 1ns/1ps
module tb_barker_framer;

    localparam int GUARD_LEN = 8;
    localparam logic [12:0] PRE = 13'b1111100110101;
`ifdef BARKER_FRAMER_GUARD_EN
    localparam int EXP_GAP = GUARD_LEN;
`else
    localparam int EXP_GAP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_s_tdata = 8'h00, b_s_tdata = 8'h00;
    logic a_s_tvalid = 1'b0, a_s_tlast = 1'b0, a_m_tready = 1'b0;
    logic b_s_tvalid = 1'b0, b_s_tlast = 1'b0, b_m_tready = 1'b0;
    logic a_s_tready, a_m_tdata, a_m_tvalid, a_m_tlast, a_short;
    logic b_s_tready, b_m_tdata, b_m_tvalid, b_m_tlast, b_short;

    barker_framer #(.PAYLOAD_BYTES(4), .GUARD_LEN(GUARD_LEN)) u_dut4 (
        .i_clk(clk), .i_rst(rst),
        .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tlast(a_s_tlast),
        .s_axis_tready(a_s_tready),
        .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tlast(a_m_tlast),
        .m_axis_tready(a_m_tready), .o_short(a_short)
    );

    barker_framer #(.PAYLOAD_BYTES(1), .GUARD_LEN(GUARD_LEN)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tlast(b_s_tlast),
        .s_axis_tready(b_s_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tlast(b_m_tlast),
        .m_axis_tready(b_m_tready), .o_short(b_short)
    );

    typedef struct packed { logic v; logic d; logic l; logic r; logic sh; } mon_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] a_src[$], b_src[$];   // {tlast, tdata} waiting to be offered
    logic [1:0] a_exp[$], b_exp[$];   // {tlast, chip} expected downstream
    mon_t a_mon, b_mon;
    bit   m_in[2];
    int   m_cnt[2];

    task automatic push_exp(input bit to_b, input logic [1:0] e);
        if (to_b) b_exp.push_back(e); else a_exp.push_back(e);
    endtask

    // Offer one byte and queue the chips the framer must emit for it.
    task automatic send_byte(input bit to_b, input logic [7:0] data, input logic last);
        int pb;
        bit fin;
        pb = to_b ? 1 : 4;
        if (to_b) b_src.push_back({last, data}); else a_src.push_back({last, data});
        if (!m_in[to_b]) begin
            for (int k = 12; k >= 0; k--) push_exp(to_b, {1'b0, PRE[k]});
            m_in[to_b]  = 1'b1;
            m_cnt[to_b] = 0;
        end
        m_cnt[to_b] = m_cnt[to_b] + 1;
        fin = (m_cnt[to_b] == pb) || (last == 1'b1);
        for (int k = 7; k >= 0; k--) push_exp(to_b, {fin && (k == 0), data[k]});
        if (fin) m_in[to_b] = 1'b0;
    endtask

    task automatic flush_model();
        a_src.delete(); b_src.delete(); a_exp.delete(); b_exp.delete();
        m_in[0] = 1'b0; m_in[1] = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
        a_s_tvalid = 1'b0; b_s_tvalid = 1'b0;
    endtask

    // One clock: drive after the edge, sample both DUTs at the falling edge.
    task automatic tick(input logic ra, input logic rb);
        @(posedge clk); #1;
        a_m_tready = ra;
        b_m_tready = rb;
        a_s_tvalid = (a_src.size() != 0);
        a_s_tdata = 8'h00; a_s_tlast = 1'b0;
        if (a_s_tvalid) begin a_s_tdata = a_src[0][7:0]; a_s_tlast = a_src[0][8]; end
        b_s_tvalid = (b_src.size() != 0);
        b_s_tdata = 8'h00; b_s_tlast = 1'b0;
        if (b_s_tvalid) begin b_s_tdata = b_src[0][7:0]; b_s_tlast = b_src[0][8]; end
        @(negedge clk);
        a_mon = {a_m_tvalid, a_m_tdata, a_m_tlast, a_m_tready, a_short};
        b_mon = {b_m_tvalid, b_m_tdata, b_m_tlast, b_m_tready, b_short};
        if (a_s_tvalid && a_s_tready) void'(a_src.pop_front());
        if (b_s_tvalid && b_s_tready) void'(b_src.pop_front());
    endtask

    task automatic test_reset();
        logic [9:0] got;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {a_m_tvalid, a_s_tready, a_m_tdata, a_m_tlast, a_short,
               b_m_tvalid, b_s_tready, b_m_tdata, b_m_tlast, b_short};
        n_checks++;
        if (got !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 0000000000", got);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_m_tvalid, b_m_tvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: tvalid a/b=%b, want 00", {a_m_tvalid, b_m_tvalid});
        end
    endtask

    task automatic test_single_byte();
        logic [1:0] e;
        int cyc, beats, first_v, last_pos, last_cyc, shorts;
        cyc = 0; beats = 0; first_v = -1; last_pos = -1; last_cyc = -1; shorts = 0;
        send_byte(1'b1, 8'hA5, 1'b0);
        while (b_exp.size() != 0 && cyc < 100) begin
            tick(1'b1, 1'b1);
            if (b_mon.v && first_v < 0) first_v = cyc;
            if (b_mon.sh) shorts++;
            if (b_mon.v && b_mon.r) begin
                e = b_exp.pop_front();
                beats++;
                n_checks++;
                if ({b_mon.l, b_mon.d} !== e) begin
                    n_fail++;
                    $display("FAIL single_bit%0d: got last/data=%b, want %b", beats, {b_mon.l, b_mon.d}, e);
                end
                if (b_mon.l) begin last_pos = beats; last_cyc = cyc; end
            end
            cyc++;
        end
        n_checks++;
        if (b_exp.size() != 0) begin n_fail++; $display("FAIL single_timeout: %0d chips missing, want 0", b_exp.size()); end
        n_checks++;
        if (last_pos != 21) begin n_fail++; $display("FAIL single_tlast_pos: got %0d, want 21", last_pos); end
        n_checks++;
        if (last_cyc - first_v + 1 != 22) begin n_fail++; $display("FAIL single_span: got %0d cycles, want 22", last_cyc - first_v + 1); end
        n_checks++;
        if (shorts != 0) begin n_fail++; $display("FAIL single_short: got %0d pulses, want 0", shorts); end
    endtask

    task automatic test_stall();
        logic [1:0] e;
        mon_t prev;
        int cyc, beats, lasts, shorts, holds;
        cyc = 0; beats = 0; lasts = 0; shorts = 0; holds = 0;
        prev = '0;
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'hFF, 1'b0);
        send_byte(1'b0, 8'h0F, 1'b0);
        send_byte(1'b0, 8'hF0, 1'b1);
        while (a_exp.size() != 0 && cyc < 300) begin
            tick(~cyc[0], 1'b1);
            if (prev.v && !prev.r) begin
                holds++;
                n_checks++;
                if (!a_mon.v || a_mon.d !== prev.d || a_mon.l !== prev.l) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v/d/l=%b%b%b, want 1%b%b", a_mon.v, a_mon.d, a_mon.l, prev.d, prev.l);
                end
            end
            if (a_mon.sh) shorts++;
            if (a_mon.v && a_mon.r) begin
                e = a_exp.pop_front();
                beats++;
                if (a_mon.l) lasts++;
                n_checks++;
                if ({a_mon.l, a_mon.d} !== e) begin
                    n_fail++;
                    $display("FAIL stall_bit%0d: got last/data=%b, want %b", beats, {a_mon.l, a_mon.d}, e);
                end
            end
            prev = a_mon;
            cyc++;
        end
        n_checks++;
        if (beats != 45 || a_exp.size() != 0) begin n_fail++; $display("FAIL stall_beats: got %0d, want 45", beats); end
        n_checks++;
        if (lasts != 1) begin n_fail++; $display("FAIL stall_tlast_count: got %0d, want 1", lasts); end
        n_checks++;
        if (holds == 0) begin n_fail++; $display("FAIL stall_seen: got %0d stalled cycles, want >0", holds); end
        n_checks++;
        if (shorts != 0) begin n_fail++; $display("FAIL stall_short: got %0d pulses, want 0", shorts); end
    endtask

    task automatic test_short_frame();
        logic [1:0] e;
        int cyc, beats, last_pos, shorts, short_on_last;
        cyc = 0; beats = 0; last_pos = -1; shorts = 0; short_on_last = 0;
        send_byte(1'b0, 8'h3C, 1'b0);
        send_byte(1'b0, 8'h81, 1'b1);
        while (a_exp.size() != 0 && cyc < 200) begin
            tick(1'b1, 1'b1);
            if (a_mon.sh) begin
                shorts++;
                if (a_mon.v && a_mon.r && a_mon.l) short_on_last++;
            end
            if (a_mon.v && a_mon.r) begin
                e = a_exp.pop_front();
                beats++;
                if (a_mon.l) last_pos = beats;
                n_checks++;
                if ({a_mon.l, a_mon.d} !== e) begin
                    n_fail++;
                    $display("FAIL short_bit%0d: got last/data=%b, want %b", beats, {a_mon.l, a_mon.d}, e);
                end
            end
            cyc++;
        end
        repeat (2) begin tick(1'b1, 1'b1); if (a_mon.sh) shorts++; end
        n_checks++;
        if (beats != 29 || a_exp.size() != 0) begin n_fail++; $display("FAIL short_beats: got %0d, want 29", beats); end
        n_checks++;
        if (last_pos != 29) begin n_fail++; $display("FAIL short_tlast_pos: got %0d, want 29", last_pos); end
        n_checks++;
        if (shorts != 1 || short_on_last != 1) begin
            n_fail++;
            $display("FAIL short_pulse: got %0d pulses (%0d on final beat), want 1 (1)", shorts, short_on_last);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [1:0] e;
        logic [4:0] got;
        int cyc, beats;
        cyc = 0; beats = 0;
        send_byte(1'b0, 8'h11, 1'b0);
        send_byte(1'b0, 8'h22, 1'b0);
        while (beats < 6 && cyc < 60) begin
            tick(1'b1, 1'b1);
            if (a_mon.v && a_mon.r) begin
                e = a_exp.pop_front();
                beats++;
                n_checks++;
                if ({a_mon.l, a_mon.d} !== e) begin
                    n_fail++;
                    $display("FAIL rstmid_bit%0d: got last/data=%b, want %b", beats, {a_mon.l, a_mon.d}, e);
                end
            end
            cyc++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (a_m_tvalid !== 1'b1 || a_m_tdata !== PRE[6]) begin
            n_fail++;
            $display("FAIL rstmid_bit6_present: got v/d=%b%b, want 1%b", a_m_tvalid, a_m_tdata, PRE[6]);
        end
        rst = 1'b1;
        #1;
        got = {a_m_tvalid, a_m_tdata, a_m_tlast, a_s_tready, a_short};
        n_checks++;
        if (got !== 5'b0) begin
            n_fail++;
            $display("FAIL rstmid_async_clear: got v/d/l/rdy/short=%b, want 00000", got);
        end
        flush_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0; beats = 0;
        send_byte(1'b0, 8'h5A, 1'b1);
        while (a_exp.size() != 0 && cyc < 100) begin
            tick(1'b1, 1'b1);
            if (a_mon.v && a_mon.r) begin
                e = a_exp.pop_front();
                beats++;
                n_checks++;
                if ({a_mon.l, a_mon.d} !== e) begin
                    n_fail++;
                    $display("FAIL restart_bit%0d: got last/data=%b, want %b", beats, {a_mon.l, a_mon.d}, e);
                end
            end
            cyc++;
        end
        n_checks++;
        if (beats != 21 || a_exp.size() != 0) begin n_fail++; $display("FAIL restart_beats: got %0d, want 21", beats); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        int cyc, beats, lasts, first_v, last1_cyc, gap, next_v;
        cyc = 0; beats = 0; lasts = 0; first_v = -1; last1_cyc = -1; gap = 0; next_v = -1;
        for (int i = 0; i < 8; i++) send_byte(1'b0, 8'(8'hA1 + 8'(i * 17)), 1'b0);
        while (a_exp.size() != 0 && cyc < 400) begin
            tick(1'b1, 1'b1);
            if (a_mon.v && first_v < 0) first_v = cyc;
            if (last1_cyc >= 0 && next_v < 0) begin
                if (a_mon.v) next_v = cyc; else gap++;
            end
            if (a_mon.v && a_mon.r) begin
                e = a_exp.pop_front();
                beats++;
                n_checks++;
                if ({a_mon.l, a_mon.d} !== e) begin
                    n_fail++;
                    $display("FAIL b2b_bit%0d: got last/data=%b, want %b", beats, {a_mon.l, a_mon.d}, e);
                end
                if (a_mon.l) begin
                    lasts++;
                    if (last1_cyc < 0) last1_cyc = cyc;
                end
            end
            cyc++;
        end
        n_checks++;
        if (beats != 90 || lasts != 2) begin n_fail++; $display("FAIL b2b_beats: got %0d beats %0d tlast, want 90 and 2", beats, lasts); end
        n_checks++;
        if (last1_cyc - first_v + 1 != 49) begin n_fail++; $display("FAIL b2b_span: got %0d cycles, want 49", last1_cyc - first_v + 1); end
        n_checks++;
        if (gap != EXP_GAP) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles, want %0d", gap, EXP_GAP); end
    endtask

    task automatic test_correlator();
        logic [1:0] e;
        logic [12:0] sreg;
        int cyc, pos, peaks, bad_off;
        cyc = 0; pos = 0; peaks = 0; bad_off = 0; sreg = '0;
        repeat (3) send_byte(1'b1, 8'hA5, 1'b0);
        while (b_exp.size() != 0 && cyc < 300) begin
            tick(1'b1, 1'b1);
            if (b_mon.v && b_mon.r) begin
                e = b_exp.pop_front();
                n_checks++;
                if ({b_mon.l, b_mon.d} !== e) begin
                    n_fail++;
                    $display("FAIL corr_bit: got last/data=%b, want %b", {b_mon.l, b_mon.d}, e);
                end
                sreg = {sreg[11:0], b_mon.d};
                pos++;
                if (sreg == 13'h1F35) begin
                    peaks++;
                    if (pos != 13) bad_off++;
                end
                if (b_mon.l) pos = 0;
            end
            cyc++;
        end
        n_checks++;
        if (peaks != 3) begin n_fail++; $display("FAIL corr_peaks: got %0d, want 3", peaks); end
        n_checks++;
        if (bad_off != 0) begin n_fail++; $display("FAIL corr_offset: got %0d misplaced peaks, want 0", bad_off); end
    endtask

    task automatic settle();
        repeat (GUARD_LEN + 4) tick(1'b1, 1'b1);
    endtask

    initial begin
        m_in[0] = 1'b0; m_in[1] = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
        test_reset();
        test_single_byte();
        settle();
        test_stall();
        settle();
        test_short_frame();
        settle();
        test_reset_mid_frame();
        settle();
        test_back_to_back();
        settle();
        test_correlator();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/barker_framer.md
BARKER_FRAMER -- requirements
Module: barker_framer

Interface
REQ-001 The block SHALL have parameter PAYLOAD_BYTES, default 4, giving the payload bytes per frame (range 1..255).
REQ-002 The block SHALL have parameter GUARD_LEN, default 8, giving the idle cycles after each frame when the guard feature is compiled in (range 1..255).
REQ-003 The block SHALL have port i_clk, input, width 1, the single clock for all logic.
REQ-004 The block SHALL have port i_rst, input, width 1, the reset: asynchronous, active-high.
REQ-005 The block SHALL have port s_axis_tdata, input, width 8, the payload byte.
REQ-006 The block SHALL have port s_axis_tvalid, input, width 1, marking the payload byte valid.
REQ-007 The block SHALL have port s_axis_tlast, input, width 1, marking the last payload byte of a frame.
REQ-008 The block SHALL have port s_axis_tready, output, width 1, indicating the block accepts a payload byte.
REQ-009 The block SHALL have port m_axis_tdata, output, width 1, the serial bit to the correlator (1 = +1 chip).
REQ-010 The block SHALL have port m_axis_tvalid, output, width 1, marking the serial bit valid.
REQ-011 The block SHALL have port m_axis_tlast, output, width 1, marking the last bit of a frame.
REQ-012 The block SHALL have port m_axis_tready, input, width 1, the downstream ready.
REQ-013 The block SHALL have port o_short, output, width 1, a one-cycle pulse flagging a frame terminated early by s_axis_tlast.

Function
REQ-014 The frame SHALL consist of the Barker-13 preamble 1111100110101 sent left bit first, then the payload bits MSB-first per byte.
REQ-015 The FSM SHALL have states IDLE, PRE, LOAD, SHIFT and GAP (GAP exists only with the guard feature).
REQ-016 IDLE SHALL keep m_axis_tvalid=0 and s_axis_tready=0, and SHALL move to PRE when s_axis_tvalid=1; the waiting byte is not consumed.
REQ-017 PRE SHALL hold m_axis_tvalid=1 and present preamble bit k, advance k only on m_axis_tvalid&&m_axis_tready, and move to LOAD after bit 12 is accepted.
REQ-018 LOAD SHALL drive s_axis_tready=1 and m_axis_tvalid=0, and on s_axis_tvalid&&s_axis_tready SHALL capture the byte and its tlast, increment the byte counter, and move to SHIFT on the next cycle.
REQ-019 SHIFT SHALL present the captured byte MSB-first, advancing one bit per accepted transfer.
REQ-020 After bit 0 is accepted in SHIFT, the FSM SHALL return to LOAD if the byte counter < PAYLOAD_BYTES and the captured tlast=0; otherwise it SHALL end the frame.
REQ-021 m_axis_tlast SHALL be 1 only while bit 0 of the final byte of a frame is presented.
REQ-022 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast SHALL remain stable.
REQ-023 A captured tlast=1 arriving before the byte counter equals PAYLOAD_BYTES SHALL end the frame after that byte and SHALL pulse o_short in the cycle the final bit is accepted.
REQ-024 s_axis_tlast=0 on byte PAYLOAD_BYTES SHALL be ignored; the frame ends at the count and the next byte starts a new frame.
REQ-025 The byte counter SHALL be 8 bits wide, SHALL clear at frame end, and SHALL never wrap within a frame.
REQ-026 Throughput SHALL be 13 + 9×N cycles per N-byte frame with m_axis_tready held at 1, because of the one LOAD bubble per byte.

Reset
REQ-027 Asserting i_rst SHALL immediately force the IDLE state, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, o_short=0, and clear all counters, including mid-frame; a partial frame is discarded without a tlast.
REQ-028 After i_rst deasserts, the block SHALL start a new frame, preamble first, on the first s_axis_tvalid.

Configuration
REQ-029 With BARKER_FRAMER_GUARD_EN defined, frame end SHALL enter GAP, which holds m_axis_tvalid=0 and s_axis_tready=0 for exactly GUARD_LEN cycles and then returns to IDLE.
REQ-030 Without BARKER_FRAMER_GUARD_EN, frame end SHALL go directly to IDLE, and the GAP state and its counter SHALL not exist.

Structure
REQ-031 The package barker_pkg SHALL hold BARKER_LEN=13, the constant BARKER13=13'b1111100110101, and the framer state enum, all shared with the correlator.
REQ-032 The block SHALL be a single module with no sub-module; the preamble is indexed from the package constant.

Verification
REQ-033 The bench SHALL cover: PAYLOAD_BYTES=1, byte 0xA5, m_axis_tready=1 -> bits 1111100110101 10100101, tlast on the 21st bit, frame spanning 22 cycles.
REQ-034 The bench SHALL cover: 4 bytes 0x00,0xFF,0x0F,0xF0 with m_axis_tready toggling 1/0 -> the same 45-bit sequence, data stable on stalled cycles, exactly one tlast.
REQ-035 The bench SHALL cover: PAYLOAD_BYTES=4 with s_axis_tlast on byte 2 -> frame of 13+16 bits, tlast on bit 29, o_short pulses once.
REQ-036 The bench SHALL cover: i_rst asserted during preamble bit 6 -> m_axis_tvalid=0 in the same cycle, and the next frame restarts with preamble bit 0.
REQ-037 The bench SHALL cover: guard feature on with GUARD_LEN=8 and back-to-back frames -> exactly 8 cycles with m_axis_tvalid=0 between the last tlast and the next preamble bit.
REQ-038 The bench SHALL cover: the framer driving the correlator through axis_resync -> the monitor reports one peak per frame at a fixed offset from the preamble end.
